// File: rtl/proc_mem_subsystem.sv
// Harvard memory subsystem: single-cycle fetch port, req/ack data port, run-time program load.
// Optional even-parity protection of data memory is enabled with `define MEM_PARITY_EN.
module proc_mem_subsystem #(
    parameter int unsigned DW     = 16,
    parameter int unsigned IAW    = 6,
    parameter int unsigned DAW    = 8,
    parameter int unsigned DDEPTH = 256
) (
    input  logic           Clock,
    input  logic           Resetn,
    input  logic           i_req,
    input  logic [IAW-1:0] i_addr,
    output logic [DW-1:0]  i_data,
    output logic           i_valid,
    output logic           i_stall,
    input  logic           d_req,
    input  logic           d_we,
    input  logic [DAW-1:0] d_addr,
    input  logic [DW-1:0]  d_wdata,
    output logic [DW-1:0]  d_rdata,
    output logic           d_ack,
    output logic           d_err,
    input  logic           prog_we,
    input  logic [IAW-1:0] prog_addr,
    input  logic [DW-1:0]  prog_data
`ifdef MEM_PARITY_EN
    ,
    input  logic           inj_par_flip
`endif
);

`ifdef MEM_PARITY_EN
    localparam int unsigned MW = DW + 1;
`else
    localparam int unsigned MW = DW;
`endif

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_ERR} state_t;

    logic [DW-1:0]  r_imem [2**IAW];
    logic [MW-1:0]  r_dmem [DDEPTH];

    state_t         r_state;
    state_t         w_next;
    logic           w_cap;
    logic [DAW-1:0] r_addr;
    logic [DW-1:0]  r_wdata;
    logic [MW-1:0]  w_wword;
    logic [MW-1:0]  w_rword;
    logic           w_perr;
    logic           w_dwe;

    // Program load wins over a fetch of the same word; the fetch is refused.
    assign i_stall = Resetn & i_req & prog_we & (prog_addr == i_addr);

    always_ff @(posedge Clock) begin
        if (prog_we)
            r_imem[prog_addr] <= prog_data;
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            i_data  <= '0;
            i_valid <= 1'b0;
        end else if (i_req && !i_stall) begin
            i_data  <= r_imem[i_addr];
            i_valid <= 1'b1;
        end else begin
            i_valid <= 1'b0;
        end
    end

`ifdef MEM_PARITY_EN
    assign w_wword = {(^r_wdata) ^ inj_par_flip, r_wdata};
    assign w_perr  = ^w_rword;
`else
    assign w_wword = r_wdata;
    assign w_perr  = 1'b0;
`endif

    assign w_rword = r_dmem[r_addr];
    // Gating with Resetn keeps a write from landing on an edge that coincides with reset.
    assign w_dwe   = (r_state == S_WR) && Resetn;

    always_ff @(posedge Clock) begin
        if (w_dwe)
            r_dmem[r_addr] <= w_wword;
    end

    always_comb begin
        w_next = r_state;
        w_cap  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (d_req) begin
                    w_cap = 1'b1;
                    if (32'(d_addr) >= DDEPTH)
                        w_next = S_ERR;
                    else if (d_we)
                        w_next = S_WR;
                    else
                        w_next = S_RD;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_wdata <= '0;
            d_rdata <= '0;
            d_ack   <= 1'b0;
            d_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_cap) begin
                r_addr  <= d_addr;
                r_wdata <= d_wdata;
            end
            d_ack <= (r_state != S_IDLE);
            d_err <= (r_state == S_ERR) || ((r_state == S_RD) && w_perr);
            if (r_state == S_RD)
                d_rdata <= w_rword[DW-1:0];
        end
    end

endmodule

// File: tb/tb_proc_mem_subsystem.sv
// Scoreboard bench for proc_mem_subsystem (DDEPTH=200); parity cases run when MEM_PARITY_EN is defined.
module tb_proc_mem_subsystem;

    localparam int DW     = 16;
    localparam int IAW    = 6;
    localparam int DAW    = 8;
    localparam int DDEPTH = 200;

    logic           Clock = 1'b0;
    logic           Resetn = 1'b0;
    logic           i_req = 1'b0;
    logic [IAW-1:0] i_addr = '0;
    logic [DW-1:0]  i_data;
    logic           i_valid;
    logic           i_stall;
    logic           d_req = 1'b0;
    logic           d_we = 1'b0;
    logic [DAW-1:0] d_addr = '0;
    logic [DW-1:0]  d_wdata = '0;
    logic [DW-1:0]  d_rdata;
    logic           d_ack;
    logic           d_err;
    logic           prog_we = 1'b0;
    logic [IAW-1:0] prog_addr = '0;
    logic [DW-1:0]  prog_data = '0;
`ifdef MEM_PARITY_EN
    logic           inj = 1'b0;
`endif

    proc_mem_subsystem #(.DW(DW), .IAW(IAW), .DAW(DAW), .DDEPTH(DDEPTH)) dut (
        .Clock(Clock), .Resetn(Resetn),
        .i_req(i_req), .i_addr(i_addr), .i_data(i_data), .i_valid(i_valid), .i_stall(i_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack), .d_err(d_err),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data)
`ifdef MEM_PARITY_EN
        , .inj_par_flip(inj)
`endif
    );

    always #5 Clock = ~Clock;

    typedef struct packed { logic [DW-1:0] rd; logic err; } dexp_t;
    typedef struct packed { logic v; logic [DW-1:0] d; } fexp_t;

    dexp_t d_q[$];
    fexp_t f_q[$];

    logic [DW-1:0] m_dmem [256];
    logic          m_pbad [256];
    logic [DW-1:0] m_imem [64];
    logic [DW-1:0] m_rdata = '0;
    logic [DW-1:0] m_idata = '0;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic prev_ack = 1'b0;
    always @(negedge Clock) begin
        dexp_t e;
        if (prev_ack)
            chk("ack_pulse", 32'(d_ack), 32'(0));
        prev_ack = d_ack;
        if (d_ack) begin
            if (d_q.size() == 0) begin
                chk("ack_unexp", 32'(d_ack), 32'(0));
            end else begin
                e = d_q.pop_front();
                chk("d_rdata", 32'(d_rdata), 32'(e.rd));
                chk("d_err", 32'(d_err), 32'(e.err));
            end
        end
    end

    always @(posedge Clock) begin
        fexp_t e;
        #1;
        if (f_q.size() != 0) begin
            e = f_q.pop_front();
            chk("i_valid", 32'(i_valid), 32'(e.v));
            chk("i_data", 32'(i_data), 32'(e.d));
        end
    end

    // One fetch-port cycle; expectation is checked 1 unit after the next rising edge.
    task automatic f_cyc(input logic req, input logic [IAW-1:0] a, input logic pwe,
                         input logic [IAW-1:0] pa, input logic [DW-1:0] pd);
        fexp_t e;
        logic  st;
        i_req = req; i_addr = a; prog_we = pwe; prog_addr = pa; prog_data = pd;
        st = req & pwe & (pa == a);
        if (req && !st) begin
            m_idata = m_imem[a];
            e.v = 1'b1;
        end else begin
            e.v = 1'b0;
        end
        e.d = m_idata;
        if (pwe)
            m_imem[pa] = pd;
        f_q.push_back(e);
        #1 chk("i_stall", 32'(i_stall), 32'(st));
        @(negedge Clock);
    endtask

    // One data transaction; scr scrambles the request inputs once the request is captured.
    task automatic d_xfer(input logic we, input logic [DAW-1:0] a, input logic [DW-1:0] wd,
                          input logic scr, input logic pf);
        dexp_t e;
        int    n;
        if (int'(a) >= DDEPTH) begin
            e.rd = m_rdata; e.err = 1'b1;
        end else if (we) begin
            m_dmem[a] = wd; m_pbad[a] = pf;
            e.rd = m_rdata; e.err = 1'b0;
        end else begin
            m_rdata = m_dmem[a];
            e.rd = m_rdata; e.err = m_pbad[a];
        end
        d_q.push_back(e);
        d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd;
`ifdef MEM_PARITY_EN
        inj = pf;
`endif
        n = 0;
        do begin
            @(negedge Clock);
            n++;
            if (n == 1 && scr) begin
                d_we = ~we; d_addr = 8'($urandom); d_wdata = 16'($urandom);
            end
        end while (!d_ack && n < 8);
        chk("d_lat", 32'(n), 32'(2));
        d_req = 1'b0;
    endtask

    task automatic chk_reset_outs();
        chk("rst_i_data", 32'(i_data), 32'(0));
        chk("rst_i_valid", 32'(i_valid), 32'(0));
        chk("rst_i_stall", 32'(i_stall), 32'(0));
        chk("rst_d_rdata", 32'(d_rdata), 32'(0));
        chk("rst_d_ack", 32'(d_ack), 32'(0));
        chk("rst_d_err", 32'(d_err), 32'(0));
    endtask

    initial begin
        for (int i = 0; i < 256; i++) m_pbad[i] = 1'b0;
        repeat (3) @(negedge Clock);
        chk_reset_outs();
        Resetn = 1'b1;
        @(negedge Clock);

        f_cyc(1'b0, 6'd0, 1'b1, 6'd0, 16'h0021);
        f_cyc(1'b0, 6'd0, 1'b1, 6'd1, 16'h0001);
        f_cyc(1'b0, 6'd0, 1'b1, 6'd4, 16'h03D0);
        f_cyc(1'b1, 6'd0, 1'b0, 6'd0, 16'h0000);
        f_cyc(1'b1, 6'd1, 1'b0, 6'd0, 16'h0000);
        f_cyc(1'b1, 6'd4, 1'b0, 6'd0, 16'h0000);
        f_cyc(1'b0, 6'd0, 1'b0, 6'd0, 16'h0000);
        f_cyc(1'b1, 6'd5, 1'b1, 6'd5, 16'hBEEF);
        f_cyc(1'b1, 6'd5, 1'b0, 6'd0, 16'h0000);
        f_cyc(1'b1, 6'd4, 1'b1, 6'd6, 16'h7777);
        f_cyc(1'b1, 6'd6, 1'b0, 6'd0, 16'h0000);
        f_cyc(1'b0, 6'd0, 1'b0, 6'd0, 16'h0000);

        d_xfer(1'b1, 8'd3, 16'h0004, 1'b0, 1'b0);
        @(negedge Clock);
        d_xfer(1'b0, 8'd3, 16'h0000, 1'b0, 1'b0);
        @(negedge Clock);
        d_xfer(1'b0, 8'd250, 16'h0000, 1'b0, 1'b0);
        @(negedge Clock);
        d_xfer(1'b0, 8'd3, 16'h0000, 1'b0, 1'b0);
        d_xfer(1'b1, 8'd199, 16'h00AB, 1'b1, 1'b0);
        d_xfer(1'b0, 8'd199, 16'h0000, 1'b0, 1'b0);
        d_xfer(1'b0, 8'd200, 16'h0000, 1'b0, 1'b0);
        d_xfer(1'b1, 8'd10, 16'h5A5A, 1'b1, 1'b0);
        d_xfer(1'b0, 8'd10, 16'h0000, 1'b1, 1'b0);
        d_xfer(1'b1, 8'd0, 16'h9999, 1'b0, 1'b0);
        @(negedge Clock);
        f_cyc(1'b1, 6'd0, 1'b0, 6'd0, 16'h0000);
        f_cyc(1'b0, 6'd0, 1'b0, 6'd0, 16'h0000);

        // Reset while a load is in RD: no ack, outputs cleared.
        d_req = 1'b1; d_we = 1'b0; d_addr = 8'd3;
        @(negedge Clock);
        Resetn = 1'b0; d_req = 1'b0;
        #1 chk_reset_outs();
        m_rdata = '0; m_idata = '0;
        repeat (2) begin
            @(negedge Clock);
            chk("rst_rd_ack", 32'(d_ack), 32'(0));
        end
        Resetn = 1'b1;
        @(negedge Clock);
        d_xfer(1'b0, 8'd3, 16'h0000, 1'b0, 1'b0);
        @(negedge Clock);

        // Reset while a store is in WR: the store must not land.
        d_req = 1'b1; d_we = 1'b1; d_addr = 8'd3; d_wdata = 16'hDEAD;
        @(negedge Clock);
        Resetn = 1'b0; d_req = 1'b0;
        m_rdata = '0;
        repeat (2) begin
            @(negedge Clock);
            chk("rst_wr_ack", 32'(d_ack), 32'(0));
        end
        Resetn = 1'b1;
        @(negedge Clock);
        d_xfer(1'b0, 8'd3, 16'h0000, 1'b0, 1'b0);

`ifdef MEM_PARITY_EN
        @(negedge Clock);
        d_xfer(1'b1, 8'd7, 16'h1234, 1'b0, 1'b1);
        d_xfer(1'b0, 8'd7, 16'h0000, 1'b0, 1'b0);
        d_xfer(1'b1, 8'd7, 16'h1234, 1'b0, 1'b0);
        d_xfer(1'b0, 8'd7, 16'h0000, 1'b0, 1'b0);
`endif

        repeat (3) @(negedge Clock);
        chk("d_q_empty", 32'(d_q.size()), 32'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
